dla_gb2lb_xfer: RTL and testbench

- Executes one GB2LB transfer per go command, moving words from the global buffer (GB) into a local buffer (LB).
- Sits directly downstream of the DLA register file and consumes its decoded GB2LB_CTRL/SRC0/SRC1/DEST fields.
- Issues strided, bursted GB reads through a request/grant port and writes the returned data packed into LB.
- Reports busy status (GLB_STATUS.gb2lb) and a completion pulse (GLB_INTR.gb2lb source).

---
 rtl/dla_gb2lb_xfer.sv | 132 +++++++++++++
 tb/tb_dla_gb2lb_xfer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dla_gb2lb_xfer.sv
// GB2LB transfer engine: strided, bursted GB reads granted by an arbiter,
// returned data written packed into the local buffer.
module dla_gb2lb_xfer #(
  parameter int DATA_W    = 64,
  parameter int GB_RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_go,
  input  logic [12:0]       cfg_src_len,
  input  logic [12:0]       cfg_src_addr,
  input  logic [5:0]        cfg_src_iter,
  input  logic [12:0]       cfg_src_skip,
  input  logic [5:0]        cfg_dst_skip,
  input  logic [10:0]       cfg_dst_addr,
  output logic              gb_rd_req,
  output logic [12:0]       gb_rd_addr,
  input  logic              gb_rd_gnt,
  input  logic [DATA_W-1:0] gb_rd_data,
  output logic              lb_wr_en,
  output logic [10:0]       lb_wr_addr,
  output logic [DATA_W-1:0] lb_wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [12:0] len_q, src_skip_q, src_base_q, src_cur_q, w_q;
  logic [5:0]  iter_q, dst_skip_q, b_q;
  logic [10:0] lb_next_q;

  logic [GB_RD_LAT-1:0] rd_vld_p;
  logic [10:0]          rd_lba_p [GB_RD_LAT];

  logic issue, last_word, last_burst, pipe_empty;

  assign issue      = (state_q == RUN) && gb_rd_gnt;
  assign last_word  = (w_q == len_q - 13'd1);
  assign last_burst = (b_q == iter_q);
  assign pipe_empty = ~|rd_vld_p;

  assign gb_rd_req  = (state_q == RUN);
  assign gb_rd_addr = src_cur_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_go) state_d = (cfg_src_len == 13'd0) ? DONE : RUN;
      RUN:     if (issue && last_word && last_burst) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: shadow config, burst/word counters, GB and LB address walkers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      iter_q     <= '0;
      src_skip_q <= '0;
      dst_skip_q <= '0;
      src_base_q <= '0;
      src_cur_q  <= '0;
      lb_next_q  <= '0;
      w_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cfg_go) begin
        len_q      <= cfg_src_len;
        iter_q     <= cfg_src_iter;
        src_skip_q <= cfg_src_skip;
        dst_skip_q <= cfg_dst_skip;
        src_base_q <= cfg_src_addr;
        src_cur_q  <= cfg_src_addr;
        lb_next_q  <= cfg_dst_addr;
        w_q        <= '0;
        b_q        <= '0;
      end else if (issue) begin
        if (last_word) begin
          w_q        <= '0;
          b_q        <= b_q + 6'd1;
          src_base_q <= src_base_q + src_skip_q;
          src_cur_q  <= src_base_q + src_skip_q;
          lb_next_q  <= lb_next_q + {5'd0, dst_skip_q} + 11'd1;
        end else begin
          w_q        <= w_q + 13'd1;
          src_cur_q  <= src_cur_q + 13'd1;
          lb_next_q  <= lb_next_q + 11'd1;
        end
      end
    end
  end

  // Return pipeline: LB address travels with its read until the data arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p <= '0;
      for (int i = 0; i < GB_RD_LAT; i++) rd_lba_p[i] <= '0;
    end else begin
      rd_vld_p[0] <= issue;
      rd_lba_p[0] <= lb_next_q;
      for (int i = 1; i < GB_RD_LAT; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
        rd_lba_p[i] <= rd_lba_p[i-1];
      end
    end
  end

  // Write stage: registered LB strobe and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_wr_en   <= 1'b0;
      lb_wr_addr <= '0;
      lb_wr_data <= '0;
      done       <= 1'b0;
    end else begin
      lb_wr_en <= rd_vld_p[GB_RD_LAT-1];
      if (rd_vld_p[GB_RD_LAT-1]) begin
        lb_wr_addr <= rd_lba_p[GB_RD_LAT-1];
        lb_wr_data <= gb_rd_data;
      end
      done <= (state_q == DONE);
    end
  end

endmodule

// File: tb/tb_dla_gb2lb_xfer.sv
// Directed bench for dla_gb2lb_xfer with a GB read-latency data model.
module tb_dla_gb2lb_xfer;
  localparam int DATA_W = 64;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_go;
  logic [12:0]       cfg_src_len, cfg_src_addr, cfg_src_skip;
  logic [5:0]        cfg_src_iter, cfg_dst_skip;
  logic [10:0]       cfg_dst_addr;
  logic              gb_rd_req, gb_rd_gnt;
  logic [12:0]       gb_rd_addr;
  logic [DATA_W-1:0] gb_rd_data;
  logic              lb_wr_en;
  logic [10:0]       lb_wr_addr;
  logic [DATA_W-1:0] lb_wr_data;
  logic              busy, done;

  always #5 clk = ~clk;

  dla_gb2lb_xfer #(.DATA_W(DATA_W), .GB_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_go(cfg_go),
    .cfg_src_len(cfg_src_len), .cfg_src_addr(cfg_src_addr),
    .cfg_src_iter(cfg_src_iter), .cfg_src_skip(cfg_src_skip),
    .cfg_dst_skip(cfg_dst_skip), .cfg_dst_addr(cfg_dst_addr),
    .gb_rd_req(gb_rd_req), .gb_rd_addr(gb_rd_addr), .gb_rd_gnt(gb_rd_gnt),
    .gb_rd_data(gb_rd_data), .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr),
    .lb_wr_data(lb_wr_data), .busy(busy), .done(done)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gbd(input logic [12:0] a);
    return {16'hA5A5, 3'b000, a, 16'h5A5A, 3'b000, a};
  endfunction

  // GB memory model: data for the address issued at edge E is driven after edge E+1
  logic [12:0] a0 = '0;
  always @(posedge clk) begin
    a0         <= gb_rd_addr;
    gb_rd_data <= gbd(a0);
  end

  // Grant driver
  logic gnt_rnd = 1'b0;
  logic gnt_tie = 1'b1;
  initial begin
    gb_rd_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      gb_rd_gnt = gnt_rnd ? ($urandom_range(0, 9) < 3) : gnt_tie;
    end
  end

  // Bus monitor
  logic [12:0] rdq [$];
  logic [10:0] wraq [$];
  logic [63:0] wrdq [$];
  int          stall_viol = 0;
  logic        stall_prev = 1'b0;
  logic [12:0] addr_prev = '0;
  always @(negedge clk) begin
    if (gb_rd_req && gb_rd_gnt) rdq.push_back(gb_rd_addr);
    if (lb_wr_en) begin
      wraq.push_back(lb_wr_addr);
      wrdq.push_back(lb_wr_data);
    end
    if (stall_prev && gb_rd_req && (gb_rd_addr !== addr_prev)) stall_viol++;
    stall_prev = gb_rd_req && !gb_rd_gnt;
    addr_prev  = gb_rd_addr;
  end

  task automatic clear_q();
    rdq.delete();
    wraq.delete();
    wrdq.delete();
  endtask

  task automatic start(input logic [12:0] len, input logic [12:0] addr, input logic [5:0] iter,
                       input logic [12:0] sskip, input logic [5:0] dskip, input logic [10:0] daddr);
    clear_q();
    @(posedge clk);
    #1;
    cfg_src_len = len; cfg_src_addr = addr; cfg_src_iter = iter;
    cfg_src_skip = sskip; cfg_dst_skip = dskip; cfg_dst_addr = daddr;
    cfg_go = 1'b1;
    @(posedge clk);
    #1;
    cfg_go = 1'b0;
    cfg_src_len = 13'h0007; cfg_src_addr = 13'h0AAA; cfg_src_iter = 6'd5;
    cfg_src_skip = 13'h0333; cfg_dst_skip = 6'd9; cfg_dst_addr = 11'h555;
  endtask

  task automatic wait_done(input string tag, output int n, output logic busy1);
    n = 0;
    busy1 = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) busy1 = busy;
    end while (!done && n < 500);
    if (!done) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_seq(input string tag, input logic [12:0] er [9],
                           input logic [10:0] ew [9], input int n);
    chk({tag, "_nrd"}, 64'(rdq.size()), 64'(n));
    chk({tag, "_nwr"}, 64'(wraq.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < rdq.size())  chk($sformatf("%s_rd%0d", tag, i), 64'(rdq[i]), 64'(er[i]));
      if (i < wraq.size()) begin
        chk($sformatf("%s_wa%0d", tag, i), 64'(wraq[i]), 64'(ew[i]));
        chk($sformatf("%s_wd%0d", tag, i), wrdq[i], gbd(er[i]));
      end
    end
  endtask

  task automatic single_burst(input string tag);
    logic [12:0] er [9];
    logic [10:0] ew [9];
    int   n;
    logic b1;
    er = '{13'h010, 13'h011, 13'h012, 13'h013, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
    ew = '{11'h020, 11'h021, 11'h022, 11'h023, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0};
    start(13'd4, 13'h010, 6'd0, 13'h0, 6'd0, 11'h020);
    wait_done(tag, n, b1);
    chk({tag, "_busy_rise"}, 64'(b1), 64'd1);
    chk({tag, "_done_lat"}, 64'(n), 64'd9);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check_seq(tag, er, ew, 4);
  endtask

  initial begin
    logic [12:0] er [9];
    logic [10:0] ew [9];
    int   n, k;
    logic b1;

    rst_n = 1'b0;
    cfg_go = 1'b0;
    cfg_src_len = '0; cfg_src_addr = '0; cfg_src_iter = '0;
    cfg_src_skip = '0; cfg_dst_skip = '0; cfg_dst_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {60'd0, gb_rd_req, lb_wr_en, busy, done}, 64'd0);
    chk("rst_addr", {40'd0, gb_rd_addr, lb_wr_addr}, 64'd0);
    chk("rst_data", lb_wr_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    single_burst("t1");

    er = '{13'h100, 13'h101, 13'h102, 13'h140, 13'h141, 13'h142, 13'h180, 13'h181, 13'h182};
    ew = '{11'h000, 11'h001, 11'h002, 11'h005, 11'h006, 11'h007, 11'h00A, 11'h00B, 11'h00C};
    start(13'd3, 13'h100, 6'd2, 13'h040, 6'd2, 11'h000);
    wait_done("t2", n, b1);
    check_seq("t2", er, ew, 9);

    gnt_rnd = 1'b1;
    stall_viol = 0;
    start(13'd3, 13'h100, 6'd2, 13'h040, 6'd2, 11'h000);
    wait_done("t3", n, b1);
    chk("t3_addr_stable", 64'(stall_viol), 64'd0);
    check_seq("t3", er, ew, 9);
    gnt_rnd = 1'b0;

    er = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
    ew = '{11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0};
    start(13'd4, 13'h1FFE, 6'd0, 13'h0, 6'd0, 11'h7FE);
    wait_done("t4", n, b1);
    check_seq("t4", er, ew, 4);

    start(13'd0, 13'h050, 6'd0, 13'h0, 6'd0, 11'h050);
    wait_done("t5", n, b1);
    chk("t5_done_lat", 64'(n), 64'd2);
    chk("t5_busy", 64'(b1), 64'd1);
    repeat (2) @(negedge clk);
    chk("t5_nrd", 64'(rdq.size()), 64'd0);
    chk("t5_nwr", 64'(wraq.size()), 64'd0);

    start(13'd8, 13'h200, 6'd0, 13'h0, 6'd0, 11'h300);
    @(posedge clk);
    #1;
    cfg_src_len = 13'd2; cfg_src_addr = 13'h0555; cfg_dst_addr = 11'h111;
    cfg_go = 1'b1;
    @(posedge clk);
    #1 cfg_go = 1'b0;
    wait_done("t6", n, b1);
    repeat (3) @(negedge clk);
    chk("t6_nrd", 64'(rdq.size()), 64'd8);
    chk("t6_nwr", 64'(wraq.size()), 64'd8);
    if (rdq.size() == 8) chk("t6_rd_last", 64'(rdq[7]), 64'h207);
    if (wraq.size() == 8) begin
      chk("t6_wa_last", 64'(wraq[7]), 64'h307);
      chk("t6_wd_last", wrdq[7], gbd(13'h207));
    end

    start(13'd8, 13'h040, 6'd0, 13'h0, 6'd0, 11'h100);
    k = 0;
    while (rdq.size() < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t7_three_grants", 64'(rdq.size()), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rst_ctl", {60'd0, gb_rd_req, lb_wr_en, busy, done}, 64'd0);
    chk("t7_rst_addr", {40'd0, gb_rd_addr, lb_wr_addr}, 64'd0);
    chk("t7_rst_data", lb_wr_data, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    repeat (15) @(negedge clk);
    chk("t7_post_nrd", 64'(rdq.size()), 64'd0);
    chk("t7_post_nwr", 64'(wraq.size()), 64'd0);
    chk("t7_post_busy", 64'(busy), 64'd0);

    single_burst("t8");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
